// File: rtl/id_pkg.sv
// ============================================================================
// Package : id_pkg
// Shared decode-stage types: opcodes, ALU ops, immediate formats, bundle.
// Optional macro: ID_MEXT_EN adds the muldiv flag to the decoded bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

package id_pkg;

    localparam logic [6:0] c_OPC_R      = 7'b0110011;
    localparam logic [6:0] c_OPC_I      = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B, ALU_MULDIV
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] funct;
        alu_op_e    aluctr;
        logic       branch;
        logic       jump;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic       immadd;
        logic       illegal;
`ifdef ID_MEXT_EN
        logic       muldiv;
`endif
    } id_bundle_t;

    // SUB only exists in the register-register form; ADDI never subtracts
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt, input logic is_r);
        alu_op_e r;
        r = ALU_ADD;
        case (f3)
            3'b000: r = (alt && is_r) ? ALU_SUB : ALU_ADD;
            3'b001: r = ALU_SLL;
            3'b010: r = ALU_SLT;
            3'b011: r = ALU_SLTU;
            3'b100: r = ALU_XOR;
            3'b101: r = alt ? ALU_SRA : ALU_SRL;
            3'b110: r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_pipe_if.sv
// ============================================================================
// Interface : id_stage_pipe_if
// Fetch-side and EX-side handshake bus of the decode stage.
// Optional macro: ID_MEXT_EN adds out_muldiv.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface id_stage_pipe_if #(
    parameter int XLEN   = 32,
    parameter int PC_W   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [REG_AW-1:0] out_rs1_addr;
    logic [REG_AW-1:0] out_rs2_addr;
    logic [REG_AW-1:0] out_rd_addr;
    logic [XLEN-1:0]   out_imm;
    logic [3:0]        out_funct;
    logic [3:0]        out_aluctr;
    logic              out_branch;
    logic              out_jump;
    logic              out_memread;
    logic              out_memtoreg;
    logic              out_memwrite;
    logic              out_regwrite;
    logic              out_immadd;
    logic              out_illegal;
`ifdef ID_MEXT_EN
    logic              out_muldiv;
`endif

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs1_addr, out_rs2_addr, out_rd_addr,
               out_imm, out_funct, out_aluctr, out_branch, out_jump, out_memread,
               out_memtoreg, out_memwrite, out_regwrite, out_immadd, out_illegal
`ifdef ID_MEXT_EN
             , out_muldiv
`endif
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1_addr, out_rs2_addr, out_rd_addr,
               out_imm, out_funct, out_aluctr, out_branch, out_jump, out_memread,
               out_memtoreg, out_memwrite, out_regwrite, out_immadd, out_illegal
`ifdef ID_MEXT_EN
             , out_muldiv
`endif
    );
endinterface

`default_nettype wire

// File: rtl/id_decode_core.sv
// ============================================================================
// Module : id_decode_core
// Stateless RV32I instruction decoder producing the control bundle and immediate.
// Optional macro: ID_MEXT_EN decodes funct7=0000001 R-type as RV32M.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_decode_core
    import id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output id_bundle_t      o_bundle,
    output logic [XLEN-1:0] o_imm
);
    logic [6:0] w_opc;
    logic [6:0] w_f7;
    logic [6:0] w_f7s;
    logic [2:0] w_f3;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;
    logic       w_ill;
    logic [31:0] w_imm32;
    imm_fmt_e   w_fmt;
    id_bundle_t w_b;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];
    assign w_rs1 = i_instr[19:15];
    assign w_rs2 = i_instr[24:20];
    assign w_rd  = i_instr[11:7];
    // On RV64 instr[25] is the top shift-amount bit, not part of funct7
    assign w_f7s = (XLEN == 64) ? {w_f7[6:1], 1'b0} : w_f7;

    always_comb begin
        w_b          = '0;
        w_b.aluctr   = ALU_ADD;
        w_b.funct    = {1'b0, w_f3};
        w_fmt        = IMM_NONE;
        w_ill        = 1'b0;
        case (w_opc)
            c_OPC_R: begin
                w_b.rs1      = w_rs1;
                w_b.rs2      = w_rs2;
                w_b.rd       = w_rd;
                w_b.regwrite = 1'b1;
                w_b.funct    = {w_f7[5], w_f3};
                if (w_f7 == 7'b0000000 ||
                    (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                    w_b.aluctr = alu_from_f3(w_f3, w_f7[5], 1'b1);
                end
`ifdef ID_MEXT_EN
                else if (w_f7 == 7'b0000001) begin
                    w_b.aluctr = ALU_MULDIV;
                    w_b.funct  = {1'b0, w_f3};
                    w_b.muldiv = 1'b1;
                end
`endif
                else begin
                    w_ill = 1'b1;
                end
            end
            c_OPC_I: begin
                w_b.rs1      = w_rs1;
                w_b.rd       = w_rd;
                w_b.regwrite = 1'b1;
                w_b.immadd   = 1'b1;
                w_fmt        = IMM_I;
                w_b.aluctr   = alu_from_f3(w_f3, w_f7[5], 1'b0);
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    w_b.funct = {w_f7[5], w_f3};
                    if (!(w_f7s == 7'b0000000 || (w_f3 == 3'b101 && w_f7s == 7'b0100000)))
                        w_ill = 1'b1;
                end
            end
            c_OPC_LOAD: begin
                w_b.rs1      = w_rs1;
                w_b.rd       = w_rd;
                w_b.memread  = 1'b1;
                w_b.memtoreg = 1'b1;
                w_b.regwrite = 1'b1;
                w_b.immadd   = 1'b1;
                w_fmt        = IMM_I;
                if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_ill = 1'b1;
            end
            c_OPC_STORE: begin
                w_b.rs1      = w_rs1;
                w_b.rs2      = w_rs2;
                w_b.memwrite = 1'b1;
                w_b.immadd   = 1'b1;
                w_fmt        = IMM_S;
                if (w_f3 > 3'b010) w_ill = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_b.rs1    = w_rs1;
                w_b.rs2    = w_rs2;
                w_b.branch = 1'b1;
                w_fmt      = IMM_B;
                case (w_f3[2:1])
                    2'b00:   w_b.aluctr = ALU_SUB;
                    2'b10:   w_b.aluctr = ALU_SLT;
                    2'b11:   w_b.aluctr = ALU_SLTU;
                    default: w_ill      = 1'b1;
                endcase
            end
            c_OPC_JAL: begin
                w_b.rd       = w_rd;
                w_b.jump     = 1'b1;
                w_b.regwrite = 1'b1;
                w_fmt        = IMM_J;
            end
            c_OPC_JALR: begin
                w_b.rs1      = w_rs1;
                w_b.rd       = w_rd;
                w_b.jump     = 1'b1;
                w_b.regwrite = 1'b1;
                w_b.immadd   = 1'b1;
                w_fmt        = IMM_I;
                if (w_f3 != 3'b000) w_ill = 1'b1;
            end
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_b.rd       = w_rd;
                w_b.regwrite = 1'b1;
                w_b.immadd   = 1'b1;
                w_b.aluctr   = (w_opc == c_OPC_LUI) ? ALU_PASS_B : ALU_ADD;
                w_fmt        = IMM_U;
            end
            default: w_ill = 1'b1;
        endcase
        if (i_instr[1:0] != 2'b11) w_ill = 1'b1;
        // Illegal encodings must not touch architectural state downstream
        if (w_ill) begin
            w_b.regwrite = 1'b0;
            w_b.memread  = 1'b0;
            w_b.memwrite = 1'b0;
            w_b.branch   = 1'b0;
            w_b.jump     = 1'b0;
`ifdef ID_MEXT_EN
            w_b.muldiv   = 1'b0;
`endif
        end
        w_b.illegal = w_ill;
    end

    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm    = XLEN'($signed(w_imm32));
    assign o_bundle = w_b;

endmodule

`default_nettype wire

// File: rtl/id_stage_pipe.sv
// ============================================================================
// Module : id_stage_pipe
// Registered RV32I decode stage with valid/ready handshake, load-use stall and flush.
// Optional macro: ID_MEXT_EN enables RV32M decode and the out_muldiv output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int PC_W   = 32,
    parameter int REG_AW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    id_stage_pipe_if.slave bus
);
    id_bundle_t      w_dec;
    logic [XLEN-1:0] w_imm;
    logic            w_hazard;
    logic            w_load;

    id_bundle_t      r_dec;
    logic [XLEN-1:0] r_imm;
    logic [PC_W-1:0] r_pc;
    logic            r_valid;

    id_decode_core #(.XLEN(XLEN)) u_decode (
        .i_instr  (bus.in_instr),
        .o_bundle (w_dec),
        .o_imm    (w_imm)
    );

    // Unused source fields decode to x0, so they can never match a nonzero rd
    assign w_hazard = r_valid && r_dec.memread && (r_dec.rd != 5'd0) &&
                      ((w_dec.rs1 == r_dec.rd) || (w_dec.rs2 == r_dec.rd));

    assign bus.in_ready = bus.flush || (!w_hazard && (!r_valid || bus.out_ready));
    assign w_load       = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_dec   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_dec   <= w_dec;
            r_imm   <= w_imm;
            r_pc    <= bus.in_pc;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.out_valid    = r_valid;
    assign bus.out_pc       = r_pc;
    assign bus.out_rs1_addr = REG_AW'(r_dec.rs1);
    assign bus.out_rs2_addr = REG_AW'(r_dec.rs2);
    assign bus.out_rd_addr  = REG_AW'(r_dec.rd);
    assign bus.out_imm      = r_imm;
    assign bus.out_funct    = r_dec.funct;
    assign bus.out_aluctr   = r_dec.aluctr;
    assign bus.out_branch   = r_dec.branch;
    assign bus.out_jump     = r_dec.jump;
    assign bus.out_memread  = r_dec.memread;
    assign bus.out_memtoreg = r_dec.memtoreg;
    assign bus.out_memwrite = r_dec.memwrite;
    assign bus.out_regwrite = r_dec.regwrite;
    assign bus.out_immadd   = r_dec.immadd;
    assign bus.out_illegal  = r_dec.illegal;
`ifdef ID_MEXT_EN
    assign bus.out_muldiv   = r_dec.muldiv;
`endif

endmodule

`default_nettype wire

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered RISC-V decode stage with a valid/ready handshake on both sides. It sits between the fetch-side instruction buffer and the EX stage.
- Decodes the full RV32I base set: R, I, IL, S, B, JAL, JALR, LUI, AUIPC. Immediates are fully formatted and sign-extended to XLEN.
- Detects load-use hazards against the instruction it currently holds, and inserts a bubble when one is found.
- Supports flush on redirect, and flags illegal instructions instead of silently zeroing controls.

Parameters:
XLEN, 32, datapath/immediate width (32 or 64); immediate sign-extended from instr[31].
PC_W, 32, program counter width, passed through unchanged.
REG_AW, 5, register address width.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_instr  in  32  raw instruction
in_pc  in  PC_W  PC of in_instr
flush  in  1  kill held and incoming instruction (branch redirect)
out_valid  out  1  decoded bundle valid
out_ready  in  1  EX accepts the bundle
out_pc  out  PC_W  registered PC
out_rs1_addr, out_rs2_addr, out_rd_addr  out  REG_AW each  register addresses; unused fields are 0
out_imm  out  XLEN  formatted, sign-extended immediate
out_funct  out  4  {funct7[5],funct3}; funct7[5] is forced 0 except R-type and I-type shifts (funct3 001/101)
out_aluctr  out  4  ALU op from shared package
out_branch, out_jump, out_memread, out_memtoreg, out_memwrite, out_regwrite, out_immadd  out  1 each  control strobes
out_illegal  out  1  illegal/unsupported encoding

Behaviour:
- Reset (rst_n=0 at clk edge): every registered output is 0, including out_valid and out_illegal.
- Reset mid-transfer discards the held bundle.
- in_ready = !flush_hold && !hazard && (!out_valid || out_ready). flush_hold is always 0; flush itself forces in_ready=1.
- Load sequencing: if in_valid && in_ready, the output register loads the decoded bundle next cycle (latency 1).
- Bubble: if out_valid && out_ready and no new load occurs, out_valid goes to 0.
- Hold: if out_valid && !out_ready, all outputs hold stable. Outputs never change while out_valid && !out_ready.
- Hazard definition: hazard = out_valid && out_memread && out_rd_addr!=0 && (rs1 used && rs1==out_rd_addr || rs2 used && rs2==out_rd_addr). rs1/rs2 are taken from in_instr.
- Hazard response: while hazard is asserted, in_ready=0. When the held load leaves (out_ready), a bubble is inserted (out_valid=0). The dependent instruction is accepted the following cycle.
- Flush (highest priority): next cycle out_valid=0. The input handshake completes and the accepted instruction is dropped. The hazard is ignored.
- Opcode decode:
  - R 0110011: rs1, rs2, rd, regwrite.
  - I 0010011: rs1, rd, imm I, regwrite, immadd.
  - IL 0000011: rs1, rd, imm I, memread, memtoreg, regwrite, immadd.
  - S 0100011: rs1, rs2, imm S, memwrite, immadd; rd=0.
  - B 1100011: rs1, rs2, imm B (bit0=0), branch.
  - JAL 1101111: rd, imm J (bit0=0), jump, regwrite.
  - JALR 1100111: rs1, rd, imm I, jump, regwrite, immadd.
  - LUI 0110111: rd, imm U={instr[31:12],12'b0}, aluctr PASS_B, regwrite, immadd.
  - AUIPC 0010111: as LUI with aluctr ADD.
- aluctr:
  - R/I-type: from funct3/funct7[5], with SUB only in R.
  - Loads, stores and JALR: ADD.
  - Branches: SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
- Illegal (out_illegal=1, out_valid still 1; regwrite/memread/memwrite/branch/jump forced 0) when any of:
  - instr[1:0]!=11 or unknown opcode.
  - R-type funct7 not 0000000, and not 0100000 with funct3 000/101.
  - I-shift funct7 invalid.
  - Load funct3 011/110/111.
  - Store funct3>010.
  - B funct3 010/011.
  - JALR funct3!=0.

Optional Feature:
- ID_MEXT_EN defined: R-type with funct7=0000001 decodes as RV32M.
  - aluctr=MULDIV, out_funct={1'b0,funct3}, out_muldiv=1 (extra 1-bit output port present only with the macro), regwrite.
- Undefined: such encodings are illegal and the port is absent.

Decomposition:
- Shared package id_pkg holds:
  - opcode constants.
  - ALU op enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B, MULDIV).
  - immediate-format enum (NONE, I, S, B, U, J).
  - decoded-bundle struct type.
- One combinational sub-module id_decode_core maps instr to the bundle, with no state. id_stage_pipe owns the handshake, hazard and flush logic and the output register.

Test Plan:
- Reset: rst_n=0 for 2 clk with in_valid=1 -> out_valid=0, all outputs 0. First accept occurs the cycle after rst_n=1.
- Immediate formats:
  - ADDI x1,x0,-1 (0xFFF00093) -> out_imm=0xFFFFFFFF, rd=1, regwrite, immadd, aluctr ADD, 1-cycle latency.
  - BEQ offset -4 (0xFE000EE3) -> out_imm=0xFFFFFFFC, branch=1, regwrite=0.
- Load-use: LW x5,0(x1), then ADD x6,x5,x2 -> in_ready=0 for 1 cycle, one bubble (out_valid=0) between them. ADD x6,x0,x2 behind the load -> no bubble.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. Releasing gives one transfer per cycle thereafter.
- Flush: flush=1 while holding a valid bundle and accepting a new one -> next cycle out_valid=0. Neither instruction ever appears at the output.
- Illegal: 0x00000000 and MUL x1,x2,x3 (0x023100B3) without ID_MEXT_EN -> out_valid=1, out_illegal=1, all write strobes 0. With the macro, MUL gives aluctr=MULDIV, out_muldiv=1.
